// File: rtl/data_mem_subsystem.sv
// ----------------------------------------------------------------------------
// data_mem_subsystem
//  MEM-stage data path: word-wide data RAM, store/load formatters and a
//  per-word dirty-bit tracker. All outputs are combinational; the enclosing
//  MEM/WB stage registers them.
//
// Ports
//  i_clock        single clock, all state updates on posedge
//  i_reset        synchronous active-high reset (clears dirty bits only)
//  i_mem_enable   1 = memory may read/write this cycle
//  i_MEM_control  [5]=read [4]=write [3]=signed [2:0]=size (001 word,
//                 010 half, 100 byte; anything else behaves as word)
//  i_addr         word address
//  i_data_write   store data from the register file
//  o_data_raw     unformatted word at i_addr (debug dump path)
//  o_mem_data     size-selected, sign/zero-extended load data
//  o_bit_sucio    dirty bit of the word at i_addr
// ----------------------------------------------------------------------------
module data_mem_subsystem #(
   parameter int NB_DATA     = 32,
   parameter int NB_MEM_CTRL = 6,
   parameter int ADDRWIDTH   = 7
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_mem_enable,
   input  logic [NB_MEM_CTRL-1:0] i_MEM_control,
   input  logic [ADDRWIDTH-1:0]   i_addr,
   input  logic [NB_DATA-1:0]     i_data_write,
   output logic [NB_DATA-1:0]     o_data_raw,
   output logic [NB_DATA-1:0]     o_mem_data,
   output logic                   o_bit_sucio
);

   localparam int DEPTH = 2**ADDRWIDTH;

   localparam logic [2:0] SZ_WORD = 3'b001;
   localparam logic [2:0] SZ_HALF = 3'b010;
   localparam logic [2:0] SZ_BYTE = 3'b100;

   // control decode
   logic       rd;
   logic       wr;
   logic       sgn;
   logic [2:0] size;

   assign rd   = i_MEM_control[5];
   assign wr   = i_MEM_control[4];
   assign sgn  = i_MEM_control[3];
   assign size = i_MEM_control[2:0];

   // store formatter: sub-word stores are zero-padded to a full word, so a
   // byte/half store overwrites the whole word rather than merging lanes
   logic [NB_DATA-1:0] wdata;

   always_comb begin
      wdata = i_data_write;
      case (size)
         SZ_HALF: wdata = {{(NB_DATA-16){1'b0}}, i_data_write[15:0]};
         SZ_BYTE: wdata = {{(NB_DATA-8){1'b0}},  i_data_write[7:0]};
         default: wdata = i_data_write;
      endcase
   end

   // data RAM: no reset on contents, so data survives a pipeline reset
   logic [NB_DATA-1:0] mem [DEPTH];
   logic               do_write;

   assign do_write = i_mem_enable & wr & ~i_reset;

   always_ff @(posedge i_clock) begin
      if (do_write) mem[i_addr] <= wdata;
   end

   // asynchronous read; same-cycle write shows up only after the edge
   assign o_data_raw = (i_mem_enable & rd) ? mem[i_addr] : '0;

   // load formatter, operating on the already-gated raw word
   always_comb begin
      o_mem_data = o_data_raw;
      case (size)
         SZ_HALF: o_mem_data = sgn ? {{(NB_DATA-16){o_data_raw[15]}}, o_data_raw[15:0]}
                                   : {{(NB_DATA-16){1'b0}},           o_data_raw[15:0]};
         SZ_BYTE: o_mem_data = sgn ? {{(NB_DATA-8){o_data_raw[7]}},   o_data_raw[7:0]}
                                   : {{(NB_DATA-8){1'b0}},            o_data_raw[7:0]};
         default: o_mem_data = o_data_raw;
      endcase
   end

   // dirty tracker: sticky per-word flag, cleared only by reset, so the debug
   // unit can dump just the words touched since the last reset
   logic [DEPTH-1:0] dirty;

   always_ff @(posedge i_clock) begin
      if (i_reset)                  dirty         <= '0;
      else if (i_mem_enable && wr)  dirty[i_addr] <= 1'b1;
   end

   assign o_bit_sucio = dirty[i_addr];

endmodule

// File: tb/tb_data_mem_subsystem.sv
module tb_data_mem_subsystem;

   localparam int NB_DATA     = 32;
   localparam int NB_MEM_CTRL = 6;
   localparam int ADDRWIDTH   = 7;
   localparam int DEPTH       = 2**ADDRWIDTH;

   logic                   i_clock;
   logic                   i_reset;
   logic                   i_mem_enable;
   logic [NB_MEM_CTRL-1:0] i_MEM_control;
   logic [ADDRWIDTH-1:0]   i_addr;
   logic [NB_DATA-1:0]     i_data_write;
   logic [NB_DATA-1:0]     o_data_raw;
   logic [NB_DATA-1:0]     o_mem_data;
   logic                   o_bit_sucio;

   int checks = 0;
   int errors = 0;

   data_mem_subsystem #(
      .NB_DATA(NB_DATA), .NB_MEM_CTRL(NB_MEM_CTRL), .ADDRWIDTH(ADDRWIDTH)
   ) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_mem_enable(i_mem_enable),
      .i_MEM_control(i_MEM_control), .i_addr(i_addr), .i_data_write(i_data_write),
      .o_data_raw(o_data_raw), .o_mem_data(o_mem_data), .o_bit_sucio(o_bit_sucio)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   // advance one clock edge; inputs change and outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_mem_enable = 1'b0; i_MEM_control = 6'b0;
      i_addr = '0; i_data_write = '0;
      tick(); tick();
      i_reset = 1'b0; i_mem_enable = 1'b1; i_MEM_control = 6'b101001;
      for (int a = 0; a < DEPTH; a++) begin
         i_addr = a[ADDRWIDTH-1:0];
         #1;
         checks++;
         if (o_data_raw !== 32'h0) begin
            errors++; $display("FAIL reset_raw addr=%0d got=%h exp=%h", a, o_data_raw, 32'h0);
         end
         checks++;
         if (o_mem_data !== 32'h0) begin
            errors++; $display("FAIL reset_mem addr=%0d got=%h exp=%h", a, o_mem_data, 32'h0);
         end
         checks++;
         if (o_bit_sucio !== 1'b0) begin
            errors++; $display("FAIL reset_dirty addr=%0d got=%b exp=0", a, o_bit_sucio);
         end
      end
   endtask

   task automatic test_word();
      i_addr = 7'd5; i_data_write = 32'hDEADBEEF; i_MEM_control = 6'b011001;
      #1;
      checks++;
      if (o_bit_sucio !== 1'b0) begin
         errors++; $display("FAIL word_dirty_pre got=%b exp=0", o_bit_sucio);
      end
      tick();
      i_MEM_control = 6'b101001; #1;
      checks++;
      if (o_mem_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL word_load got=%h exp=%h", o_mem_data, 32'hDEADBEEF);
      end
      checks++;
      if (o_bit_sucio !== 1'b1) begin
         errors++; $display("FAIL word_dirty5 got=%b exp=1", o_bit_sucio);
      end
      i_addr = 7'd6; #1;
      checks++;
      if (o_bit_sucio !== 1'b0) begin
         errors++; $display("FAIL word_dirty6 got=%b exp=0", o_bit_sucio);
      end
      // read+write same address: old word before the edge, new word after
      i_addr = 7'd7; i_data_write = 32'h11223344; i_MEM_control = 6'b111001; #1;
      checks++;
      if (o_data_raw !== 32'h0) begin
         errors++; $display("FAIL rw_before got=%h exp=%h", o_data_raw, 32'h0);
      end
      tick();
      checks++;
      if (o_data_raw !== 32'h11223344) begin
         errors++; $display("FAIL rw_after got=%h exp=%h", o_data_raw, 32'h11223344);
      end
      // undefined size code behaves as word on both store and load
      i_addr = 7'd8; i_data_write = 32'hCAFEF00D; i_MEM_control = 6'b011000;
      tick();
      i_MEM_control = 6'b101011; #1;
      checks++;
      if (o_mem_data !== 32'hCAFEF00D) begin
         errors++; $display("FAIL size_other got=%h exp=%h", o_mem_data, 32'hCAFEF00D);
      end
   endtask

   task automatic test_byte();
      i_addr = 7'd2; i_data_write = 32'h12345680; i_MEM_control = 6'b011100;
      tick();
      i_MEM_control = 6'b101100; #1;
      checks++;
      if (o_mem_data !== 32'hFFFFFF80) begin
         errors++; $display("FAIL byte_signed got=%h exp=%h", o_mem_data, 32'hFFFFFF80);
      end
      i_MEM_control = 6'b100100; #1;
      checks++;
      if (o_mem_data !== 32'h00000080) begin
         errors++; $display("FAIL byte_unsigned got=%h exp=%h", o_mem_data, 32'h00000080);
      end
      checks++;
      if (o_data_raw !== 32'h00000080) begin
         errors++; $display("FAIL byte_raw got=%h exp=%h", o_data_raw, 32'h00000080);
      end
      // sub-word loads from a full word
      i_addr = 7'd5; i_MEM_control = 6'b101100; #1;
      checks++;
      if (o_mem_data !== 32'hFFFFFFEF) begin
         errors++; $display("FAIL byte_of_word got=%h exp=%h", o_mem_data, 32'hFFFFFFEF);
      end
      i_MEM_control = 6'b100010; #1;
      checks++;
      if (o_mem_data !== 32'h0000BEEF) begin
         errors++; $display("FAIL half_u_of_word got=%h exp=%h", o_mem_data, 32'h0000BEEF);
      end
   endtask

   task automatic test_half();
      i_addr = 7'd3; i_data_write = 32'hAAAA8001; i_MEM_control = 6'b011010;
      tick();
      i_MEM_control = 6'b101010; #1;
      checks++;
      if (o_mem_data !== 32'hFFFF8001) begin
         errors++; $display("FAIL half_signed got=%h exp=%h", o_mem_data, 32'hFFFF8001);
      end
      i_MEM_control = 6'b100010; #1;
      checks++;
      if (o_mem_data !== 32'h00008001) begin
         errors++; $display("FAIL half_unsigned got=%h exp=%h", o_mem_data, 32'h00008001);
      end
      i_MEM_control = 6'b101001; #1;
      checks++;
      if (o_mem_data !== 32'h00008001) begin
         errors++; $display("FAIL half_word_view got=%h exp=%h", o_mem_data, 32'h00008001);
      end
      i_MEM_control = 6'b101100; #1;
      checks++;
      if (o_mem_data !== 32'h00000001) begin
         errors++; $display("FAIL byte_signed_pos got=%h exp=%h", o_mem_data, 32'h00000001);
      end
   endtask

   task automatic test_disabled();
      i_mem_enable = 1'b0; i_addr = 7'd9; i_data_write = 32'h55555555;
      i_MEM_control = 6'b011001;
      tick();
      i_MEM_control = 6'b101001; #1;
      checks++;
      if (o_data_raw !== 32'h0) begin
         errors++; $display("FAIL dis_raw got=%h exp=%h", o_data_raw, 32'h0);
      end
      i_addr = 7'd5; #1;
      checks++;
      if (o_mem_data !== 32'h0) begin
         errors++; $display("FAIL dis_mem got=%h exp=%h", o_mem_data, 32'h0);
      end
      i_mem_enable = 1'b1; i_addr = 7'd9; #1;
      checks++;
      if (o_data_raw !== 32'h0) begin
         errors++; $display("FAIL dis_mem9 got=%h exp=%h", o_data_raw, 32'h0);
      end
      checks++;
      if (o_bit_sucio !== 1'b0) begin
         errors++; $display("FAIL dis_dirty9 got=%b exp=0", o_bit_sucio);
      end
      // enabled but no read: formatted output still 0
      i_addr = 7'd5; i_MEM_control = 6'b001001; #1;
      checks++;
      if (o_mem_data !== 32'h0) begin
         errors++; $display("FAIL noread_mem got=%h exp=%h", o_mem_data, 32'h0);
      end
   endtask

   task automatic test_reset_mid();
      i_reset = 1'b1; i_mem_enable = 1'b1; i_addr = 7'd10;
      i_data_write = 32'h77777777; i_MEM_control = 6'b011001;
      tick();
      i_reset = 1'b0; i_MEM_control = 6'b101001; #1;
      checks++;
      if (o_data_raw !== 32'h0) begin
         errors++; $display("FAIL rst_drop_data got=%h exp=%h", o_data_raw, 32'h0);
      end
      checks++;
      if (o_bit_sucio !== 1'b0) begin
         errors++; $display("FAIL rst_drop_dirty got=%b exp=0", o_bit_sucio);
      end
      i_addr = 7'd5; #1;
      checks++;
      if (o_data_raw !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rst_keep5 got=%h exp=%h", o_data_raw, 32'hDEADBEEF);
      end
      i_addr = 7'd2; #1;
      checks++;
      if (o_data_raw !== 32'h00000080) begin
         errors++; $display("FAIL rst_keep2 got=%h exp=%h", o_data_raw, 32'h00000080);
      end
      for (int a = 0; a < DEPTH; a++) begin
         i_addr = a[ADDRWIDTH-1:0];
         #1;
         checks++;
         if (o_bit_sucio !== 1'b0) begin
            errors++; $display("FAIL rst_dirty addr=%0d got=%b exp=0", a, o_bit_sucio);
         end
      end
      // normal writes resume after reset
      i_addr = 7'd10; i_MEM_control = 6'b011001;
      tick();
      i_MEM_control = 6'b101001; #1;
      checks++;
      if (o_bit_sucio !== 1'b1) begin
         errors++; $display("FAIL post_rst_dirty got=%b exp=1", o_bit_sucio);
      end
      checks++;
      if (o_data_raw !== 32'h77777777) begin
         errors++; $display("FAIL post_rst_data got=%h exp=%h", o_data_raw, 32'h77777777);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_disabled();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
